// File: rtl/fifo_msg_reader_pkg.sv
// Shared definitions for the length-prefixed FIFO message reader.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

package fifo_msg_defs;
  typedef enum logic {HDR = 1'b0, DATA = 1'b1} state_e;

  // Length field sits at the bottom of the header word.
  localparam int LEN_LSB = 0;
  localparam int FLAG_W  = 3;

  // Packed order gives {ZLM, EOM, SOM} with SOM in bit 0.
  typedef struct packed {
    logic zlm;
    logic eom;
    logic som;
  } msg_flags_t;
endpackage

// File: rtl/fifo_msg_outreg.sv
// Single-entry valid/ready output register; low FLAG_W bits are per-beat flags
// that clear when the beat leaves, while the data bits hold their last value.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module fifo_msg_outreg #(
  parameter int WIDTH  = 35,
  parameter int FLAG_W = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] word
);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid <= `BSV_ASSIGNMENT_DELAY 1'b0;
      word  <= `BSV_ASSIGNMENT_DELAY '0;
    end else if (CLR) begin
      valid              <= `BSV_ASSIGNMENT_DELAY 1'b0;
      word[FLAG_W-1:0]   <= `BSV_ASSIGNMENT_DELAY '0;
    end else if (load) begin
      valid <= `BSV_ASSIGNMENT_DELAY 1'b1;
      word  <= `BSV_ASSIGNMENT_DELAY load_word;
    end else if (valid && ready) begin
      valid              <= `BSV_ASSIGNMENT_DELAY 1'b0;
      word[FLAG_W-1:0]   <= `BSV_ASSIGNMENT_DELAY '0;
    end
  end

endmodule

// File: rtl/fifo_msg_reader.sv
// Drains a sized FIFO of length-prefixed words and emits framed SOM/EOM/ZLM beats
// through a registered valid/ready stream.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module fifo_msg_reader
  import fifo_msg_defs::*;
#(
  parameter int p1width     = 32,
  parameter int p3len_width = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CLR,
  input  logic [p1width-1:0] FIFO_D_OUT,
  input  logic               FIFO_EMPTY_N,
  output logic               FIFO_DEQ,
  output logic [p1width-1:0] OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               OUT_SOM,
  output logic               OUT_EOM,
  output logic               OUT_ZLM,
  output logic               BUSY
);

  localparam int OW = p1width + FLAG_W;
  localparam logic [p3len_width-1:0] ONE = 1;

  state_e                 state, state_nxt;
  logic [p3len_width-1:0] remaining, remaining_nxt;
  logic                   first, first_nxt;
  logic [p3len_width-1:0] len;
  logic                   load_ok, deq, load;
  logic [p1width-1:0]     ld_data;
  msg_flags_t             ld_flags, out_flags;
  logic                   out_valid;
  logic [OW-1:0]          out_word;

  // OUT_READY feeds FIFO_DEQ combinationally so a stalled beat never gets overwritten.
  assign load_ok = !out_valid || OUT_READY;
  assign deq     = RST_N && !CLR && FIFO_EMPTY_N && load_ok;
  assign len     = FIFO_D_OUT[LEN_LSB +: p3len_width];

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    first_nxt     = first;
    load          = 1'b0;
    ld_data       = '0;
    ld_flags      = '0;
    case (state)
      HDR: begin
        if (deq) begin
          if (len == '0) begin
            load         = 1'b1;
            ld_flags.som = 1'b1;
            ld_flags.eom = 1'b1;
            ld_flags.zlm = 1'b1;
          end else begin
            remaining_nxt = len;
            first_nxt     = 1'b1;
            state_nxt     = DATA;
          end
        end
      end
      DATA: begin
        if (deq) begin
          load          = 1'b1;
          ld_data       = FIFO_D_OUT;
          ld_flags.som  = first;
          ld_flags.eom  = (remaining == ONE);
          remaining_nxt = remaining - ONE;
          first_nxt     = 1'b0;
          if (remaining == ONE) state_nxt = HDR;
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      state     <= `BSV_ASSIGNMENT_DELAY HDR;
      remaining <= `BSV_ASSIGNMENT_DELAY '0;
      first     <= `BSV_ASSIGNMENT_DELAY 1'b0;
    end else begin
      state     <= `BSV_ASSIGNMENT_DELAY state_nxt;
      remaining <= `BSV_ASSIGNMENT_DELAY remaining_nxt;
      first     <= `BSV_ASSIGNMENT_DELAY first_nxt;
    end
  end

  fifo_msg_outreg #(.WIDTH(OW), .FLAG_W(FLAG_W)) u_outreg (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CLR       (CLR),
    .load      (load),
    .load_word ({ld_data, ld_flags}),
    .ready     (OUT_READY),
    .valid     (out_valid),
    .word      (out_word)
  );

  assign {OUT_DATA, out_flags} = out_word;
  assign OUT_VALID = out_valid;
  assign OUT_SOM   = out_flags.som;
  assign OUT_EOM   = out_flags.eom;
  assign OUT_ZLM   = out_flags.zlm;
  assign BUSY      = (state == DATA);
  assign FIFO_DEQ  = deq;

`ifndef SYNTHESIS
  logic          chk_stall;
  logic [OW-1:0] chk_word;

  always_ff @(posedge CLK) begin
    chk_stall <= `BSV_ASSIGNMENT_DELAY RST_N && !CLR && out_valid && !OUT_READY;
    chk_word  <= `BSV_ASSIGNMENT_DELAY out_word;
    if (FIFO_DEQ && !FIFO_EMPTY_N)
      $warning("fifo_msg_reader: dequeue from empty FIFO");
    if (chk_stall && (!out_valid || out_word != chk_word))
      $warning("fifo_msg_reader: output changed while stalled");
  end
`endif

endmodule

// File: tb/tb_fifo_msg_reader.sv
// Scoreboard bench: a queue-backed FIFO model feeds the reader, messages are
// expanded into expected beats at push time and a monitor checks every transfer.
module tb_fifo_msg_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        zlm;
    logic        eom;
    logic        som;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] FIFO_D_OUT;
  logic        FIFO_EMPTY_N;
  logic        FIFO_DEQ;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic        OUT_SOM, OUT_EOM, OUT_ZLM, BUSY;

  fifo_msg_reader #(.p1width(32), .p3len_width(16)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CLR          (CLR),
    .FIFO_D_OUT   (FIFO_D_OUT),
    .FIFO_EMPTY_N (FIFO_EMPTY_N),
    .FIFO_DEQ     (FIFO_DEQ),
    .OUT_DATA     (OUT_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_SOM      (OUT_SOM),
    .OUT_EOM      (OUT_EOM),
    .OUT_ZLM      (OUT_ZLM),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Upstream FIFO model: circular array, head word shown combinationally.
  logic [31:0] mem [0:131071];
  logic [31:0] wr_ptr = 0;
  logic [31:0] rd_ptr = 0;
  int          deq_cnt = 0;
  logic        flush = 1'b0;

  assign FIFO_D_OUT   = mem[rd_ptr[16:0]];
  assign FIFO_EMPTY_N = (rd_ptr != wr_ptr);

  always @(posedge CLK) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (FIFO_DEQ) begin
      rd_ptr  <= rd_ptr + 1;
      deq_cnt <= deq_cnt + 1;
    end
  end

  // Ready driver: 0 = fixed rdy_val, 1 = random, 2 = pattern 1,0,0.
  int   rdy_mode = 0;
  logic rdy_val = 1'b1;
  int   rdy_ph = 0;
  always @(posedge CLK) begin
    #2;
    case (rdy_mode)
      1:       OUT_READY = ($urandom % 4) != 0;
      2:       begin OUT_READY = (rdy_ph % 3) == 0; rdy_ph++; end
      default: OUT_READY = rdy_val;
    endcase
  end

  // Monitor: transfers against the scoreboard plus stream invariants.
  beat_t prev_b;
  logic  prev_stall = 1'b0;
  always @(negedge CLK) begin
    beat_t b, e;
    b = '{data: OUT_DATA, zlm: OUT_ZLM, eom: OUT_EOM, som: OUT_SOM};
    if (prev_stall) check("stall_hold", {OUT_VALID, b}, {1'b1, prev_b});
    if (FIFO_DEQ) check("deq_nonempty", FIFO_EMPTY_N, 1);
    if (RST_N && !CLR && OUT_VALID) begin
      if (!OUT_READY) check("deq_in_stall", FIFO_DEQ, 0);
      if (OUT_ZLM) check("busy_on_zlm", BUSY, 0);
      if (OUT_READY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: actual=%0h required=none", b);
        end else begin
          e = exp_q.pop_front();
          check("beat", b, e);
        end
      end
    end
    prev_stall = RST_N && !CLR && OUT_VALID && !OUT_READY;
    prev_b     = b;
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[16:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Reference model: a header of length L becomes L beats (SOM first, EOM last),
  // or one all-flags zero-data beat when L is 0.
  task automatic push_msg(input int len, input int gap_max, input bit ctr, input logic [15:0] upper);
    logic [31:0] l, d;
    l = len;
    push_word({upper, l[15:0]});
    if (len == 0) exp_q.push_back('{data: 32'h0, zlm: 1'b1, eom: 1'b1, som: 1'b1});
    for (int i = 0; i < len; i++) begin
      d = ctr ? i : $urandom;
      push_word(d);
      exp_q.push_back('{data: d, zlm: 1'b0, eom: (i == len - 1), som: (i == 0)});
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || FIFO_EMPTY_N || OUT_VALID) && c < budget) begin
      step();
      c++;
    end
    check(name, (c < budget), 1);
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (!OUT_VALID && c < 20) begin
      step();
      c++;
    end
    check(name, OUT_VALID, 1);
  endtask

  initial begin
    int          c, vcnt, d0;
    logic [31:0] w1, w2, w4;

    // Reset: everything low, and no dequeue even with a word waiting.
    repeat (3) step();
    push_word(32'h0);
    #2;
    check("rst_outputs", {OUT_VALID, OUT_SOM, OUT_EOM, OUT_ZLM, BUSY, FIFO_DEQ, OUT_DATA}, 0);
    exp_q.push_back('{data: 32'h0, zlm: 1'b1, eom: 1'b1, som: 1'b1});
    step();
    RST_N = 1'b1;
    wait_drain("drain_rst_zlm", 50);

    // Basic message: latency, back-to-back beats, dequeue count.
    d0 = deq_cnt;
    push_msg(3, 0, 0, 16'h0);
    c = 0;
    do begin step(); c++; end while (!OUT_VALID && c < 10);
    check("t1_latency", c, 2);
    vcnt = 1;
    repeat (3) begin step(); vcnt += OUT_VALID; end
    check("t1_consecutive", vcnt, 3);
    wait_drain("drain_t1", 50);
    check("t1_deq_count", deq_cnt - d0, 4);

    // Stalling downstream with a 1,0,0 ready pattern.
    rdy_mode = 2;
    push_msg(3, 0, 0, 16'h0);
    push_msg(5, 1, 0, 16'h1234);
    wait_drain("drain_t2", 200);
    rdy_mode = 0;

    // Zero-length then single-word message.
    push_msg(0, 0, 0, 16'h0);
    push_msg(1, 0, 0, 16'h0);
    wait_drain("drain_t3", 50);

    // Random traffic with upstream gaps and random backpressure.
    rdy_mode = 1;
    repeat (25) push_msg($urandom_range(0, 7), 2, 0, 16'($urandom));
    wait_drain("drain_rand", 3000);
    rdy_mode = 0;

    // CLR with an unaccepted beat: the word after the flush is a header.
    rdy_val = 1'b0;
    step();
    w1 = $urandom; w2 = $urandom; w4 = $urandom;
    push_word(32'h5); push_word(w1); push_word(w2);
    push_word(32'h1); push_word(w4); push_word(32'h0);
    exp_q.push_back('{data: w1, zlm: 1'b0, eom: 1'b0, som: 1'b1});
    wait_valid("t5_first_beat");
    rdy_val = 1'b1;
    step();
    rdy_val = 1'b0;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("t5_after_clr", {OUT_VALID, BUSY}, 0);
    exp_q.push_back('{data: w4, zlm: 1'b0, eom: 1'b1, som: 1'b1});
    exp_q.push_back('{data: 32'h0, zlm: 1'b1, eom: 1'b1, som: 1'b1});
    rdy_val = 1'b1;
    wait_drain("drain_t5", 50);

    // One-cycle reset mid-message, then a fresh two-beat message.
    rdy_val = 1'b0;
    step();
    push_word(32'h4);
    repeat (4) push_word($urandom);
    wait_valid("t6_first_beat");
    rdy_val = 1'b1;
    RST_N = 1'b0;
    flush = 1'b1;
    #2;
    check("t6_deq_in_rst", FIFO_DEQ, 0);
    step();
    flush = 1'b0;
    check("t6_rst_outputs", {OUT_VALID, OUT_SOM, OUT_EOM, OUT_ZLM, BUSY, FIFO_DEQ, OUT_DATA}, 0);
    RST_N = 1'b1;
    push_msg(2, 0, 0, 16'h0);
    wait_drain("drain_t6", 50);

    // Maximum length with ignored upper header bits.
    d0 = deq_cnt;
    push_msg(65535, 0, 1, 16'hABCD);
    wait_drain("drain_t4", 70000);
    check("t4_deq_count", deq_cnt - d0, 65536);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_msg_reader.md
Name: fifo_msg_reader

Overview:
Consumer-side companion to the team's sized FIFO. It drains a FIFO through its D_OUT/EMPTY_N/DEQ interface and converts length-prefixed words into framed messages. Output is a registered valid/ready stream carrying start-of-message (SOM), end-of-message (EOM) and zero-length-message (ZLM) markers. It sits between a sized FIFO and any downstream message consumer, for example a DMA push engine or a worker output port.

Parameters:
p1width, 32, data word width; must be >= p3len_width.
p3len_width, 16, width of the length field in the header word, in words; must be <= p1width.

Ports:
CLK  input  1  clock
RST_N  input  1  reset
CLR  input  1  synchronous flush: abort current message, drop output register
FIFO_D_OUT  input  p1width  head word of upstream FIFO
FIFO_EMPTY_N  input  1  upstream FIFO has data
FIFO_DEQ  output  1  dequeue strobe to upstream FIFO (combinational)
OUT_DATA  output  p1width  message data word
OUT_VALID  output  1  OUT_* holds a beat
OUT_READY  input  1  downstream accepts beat
OUT_SOM  output  1  first beat of message
OUT_EOM  output  1  last beat of message
OUT_ZLM  output  1  beat represents a zero-length message
BUSY  output  1  high in state DATA

Behaviour:
- Reset: RST_N is synchronous and active-low; clock is CLK.
- While reset is asserted:
  - state = HDR; remaining = 0.
  - OUT_VALID, OUT_SOM, OUT_EOM, OUT_ZLM and BUSY = 0.
  - OUT_DATA = 0.
  - FIFO_DEQ forced to 0.
- Define load_ok = !OUT_VALID || OUT_READY. A beat transfers on a cycle where OUT_VALID && OUT_READY.
- State HDR:
  - FIFO_DEQ = FIFO_EMPTY_N && load_ok && !CLR.
  - On a dequeue, len = FIFO_D_OUT[p3len_width-1:0]; the upper bits are ignored.
  - len == 0: load a single beat with OUT_DATA = 0 and SOM = EOM = ZLM = 1; stay in HDR.
  - len > 0: remaining <= len, first <= 1; go to DATA. The header word itself is never output.
- State DATA:
  - FIFO_DEQ = FIFO_EMPTY_N && load_ok && !CLR.
  - On a dequeue, load OUT_DATA = FIFO_D_OUT, SOM = first, EOM = (remaining == 1), ZLM = 0.
  - Then remaining <= remaining - 1 and first <= 0.
  - When remaining == 1, go to HDR.
- load_ok gating also applies in HDR. This keeps the header path a single FIFO_DEQ equation and prevents a ZLM beat from overwriting an unaccepted beat.
- Output register:
  - On a cycle with a load, OUT_VALID <= 1.
  - Else on a transfer, OUT_VALID <= 0 and SOM/EOM/ZLM <= 0.
  - Otherwise the register holds.
  - OUT_DATA and the flags are stable while OUT_VALID && !OUT_READY.
- Latency and throughput:
  - A FIFO word dequeued in cycle N appears on OUT_* at N+1.
  - Sustained rate is 1 data word per cycle within a message.
  - Each header costs one cycle with no output load (ZLM excepted).
  - Back-to-back messages: the EOM load and the next header dequeue occur in consecutive cycles.
- Combinational path OUT_READY -> FIFO_DEQ is intentional. Downstream must not drive OUT_READY combinationally from FIFO_DEQ.
- Upstream FIFO empty mid-message: FIFO_DEQ = 0; state and remaining hold. No timeout.
- CLR (takes priority over everything except reset):
  - state <= HDR, remaining <= 0, OUT_VALID and flags <= 0.
  - No dequeue in the CLR cycle. Partially drained message words left in the FIFO are the user's responsibility; CLR is normally paired with the FIFO's CLR.
- Maximum length 2^p3len_width - 1: the counter must not wrap; EOM is flagged on the last word.
- Simulation-only checks (translate_off): print a warning if FIFO_DEQ is asserted while FIFO_EMPTY_N is 0, or if OUT_* changes while OUT_VALID && !OUT_READY.
- Every register assignment uses the BSV_ASSIGNMENT_DELAY macro, defined empty when it is not already defined.

Decomposition:
- Shared package/include fifo_msg_defs:
  - state encoding HDR = 1'b0, DATA = 1'b1.
  - header field position, LEN_LSB = 0.
  - flag bit order {ZLM, EOM, SOM}.
- One natural sub-module: fifo_msg_outreg, a single-entry output register with load/transfer, parameter width p1width+3. The FSM/counter stays in fifo_msg_reader.

Test Plan:
1. FIFO holds hdr 3, A1, A2, A3; OUT_READY = 1 -> beats A1(SOM), A2, A3(EOM) on consecutive cycles starting 2 cycles after the first FIFO_EMPTY_N; exactly 4 FIFO_DEQ pulses.
2. Same message with OUT_READY toggling 1,0,0,1,... -> no beat lost or duplicated; OUT_DATA stable across stalls; FIFO_DEQ never asserted while OUT_VALID && !OUT_READY.
3. hdr 0, then hdr 1, B1 -> one ZLM beat (SOM = EOM = ZLM = 1, data 0), then B1 with SOM = EOM = 1, ZLM = 0; BUSY stays low for the ZLM.
4. hdr 0x0000FFFF with p3len_width = 16, streaming counter data -> exactly 65535 beats, EOM only on the last; upper header bits 0xABCD0000 ignored.
5. CLR asserted after the 2nd of 5 words while OUT_VALID = 1 -> next cycle OUT_VALID = 0 and state HDR; the following FIFO word is parsed as a header.
6. RST_N low for 1 cycle mid-message -> all outputs 0, FIFO_DEQ 0 during reset; after release a fresh hdr 2, C1, C2 yields a correct two-beat message.
